set_reset_gen: RTL and testbench

SET_RESET_GEN -- requirements
Module: set_reset_gen

---
 rtl/set_reset_gen_if.sv | 12 +
 rtl/set_reset_gen.sv | 93 +++++++++
 tb/tb_set_reset_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/set_reset_gen_if.sv
// Level-in / pulse-out bundle between a raw level source and set_reset_gen.
// The master drives the raw level; the slave returns the debounced level and SR pulses.
interface set_reset_gen_if;
    logic d;
    logic q;
    logic s;
    logic r;
    logic pending;

    modport master (output d, input q, s, r, pending);
    modport slave  (input d, output q, s, r, pending);
endinterface

// File: rtl/set_reset_gen.sv
// Synchronizes and debounces a raw level, then emits one-cycle set/reset pulses
// for an SR trigger whenever the tracked level is accepted to have changed.
module set_reset_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    set_reset_gen_if.slave bus
);

    localparam int unsigned CNT_W_RAW = $clog2(DEBOUNCE + 32'd1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 32'd1) ? 32'd1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             d_s;
    logic             q_q, q_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign d_s = bus.d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            // Shift the raw level in at bit 0; the oldest sample leaves at the top.
            always_comb begin
                sync_d    = sync_q << 1'b1;
                sync_d[0] = bus.d;
            end

            // Synchronizer chain, preloaded to the reset level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign d_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Any cycle where d_s agrees with q restarts the count, so only an
    // unbroken run of DEBOUNCE disagreeing samples is accepted.
    always_comb begin
        q_d = q_q;
        cnt_d = cnt_q;
        s_d = 1'b0;
        r_d = 1'b0;
        if (d_s == q_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = d_s;
            cnt_d = CNT_ZERO;
            s_d   = d_s;
            r_d   = ~d_s;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        pending_d = (cnt_d != CNT_ZERO);
    end

    // Tracked level, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= INIT_LEVEL;
            cnt_q     <= CNT_ZERO;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            pending_q <= pending_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.s       = s_q;
    assign bus.r       = r_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_set_reset_gen.sv
// Drives three differently parameterised set_reset_gen instances and compares
// every output each cycle against a run-length reference model of the level filter.
module tb_set_reset_gen;

    logic clk = 1'b0;
    logic rst;
    logic d_v [3];

    always #5 clk = ~clk;

    set_reset_gen_if bus_a ();
    set_reset_gen_if bus_b ();
    set_reset_gen_if bus_c ();

    assign bus_a.d = d_v[0];
    assign bus_b.d = d_v[1];
    assign bus_c.d = d_v[2];

    set_reset_gen #(.SYNC_STAGES(2), .DEBOUNCE(4), .INIT_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    set_reset_gen #(.SYNC_STAGES(0), .DEBOUNCE(1), .INIT_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));
    set_reset_gen #(.SYNC_STAGES(1), .DEBOUNCE(3), .INIT_LEVEL(1'b1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave));

    int total = 0;
    int passed = 0;

    // Reference model: d history since reset, trailing run of disagreeing samples.
    logic dhist [3][4096];
    int   n_edges [3];
    int   run [3];
    logic mq [3];
    logic ms [3];
    logic mr [3];
    logic mp [3];
    int   hold [3];

    function automatic int ss_of(input int i);
        case (i)
            0: return 2;
            1: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int db_of(input int i);
        case (i)
            0: return 4;
            1: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic init_of(input int i);
        return (i == 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic get_o(input int i, input int w);
        logic q, s, r, p;
        case (i)
            0: begin q = bus_a.q; s = bus_a.s; r = bus_a.r; p = bus_a.pending; end
            1: begin q = bus_b.q; s = bus_b.s; r = bus_b.r; p = bus_b.pending; end
            default: begin q = bus_c.q; s = bus_c.s; r = bus_c.r; p = bus_c.pending; end
        endcase
        case (w)
            0: return q;
            1: return s;
            2: return r;
            default: return p;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // The level seen after the synchronizer is d from SYNC_STAGES edges ago;
    // q flips once DEBOUNCE consecutive edges have seen the opposite level.
    task automatic model_edge(input int i);
        logic ds;
        if (rst) begin
            mq[i] = init_of(i);
            ms[i] = 1'b0;
            mr[i] = 1'b0;
            run[i] = 0;
            n_edges[i] = 0;
        end else begin
            if (n_edges[i] < 4095) n_edges[i]++;
            dhist[i][n_edges[i]] = d_v[i];
            if (n_edges[i] - ss_of(i) >= 1) ds = dhist[i][n_edges[i] - ss_of(i)];
            else ds = init_of(i);
            ms[i] = 1'b0;
            mr[i] = 1'b0;
            if (ds == mq[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == db_of(i)) begin
                    mq[i] = ds;
                    ms[i] = ds;
                    mr[i] = ~ds;
                    run[i] = 0;
                end
            end
        end
        mp[i] = (run[i] != 0);
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_q", i), get_o(i, 0), mq[i]);
            chk($sformatf("u%0d_s", i), get_o(i, 1), ms[i]);
            chk($sformatf("u%0d_r", i), get_o(i, 2), mr[i]);
            chk($sformatf("u%0d_pending", i), get_o(i, 3), mp[i]);
            chk($sformatf("u%0d_sr_excl", i), get_o(i, 1) & get_o(i, 2), 1'b0);
        end
    endtask

    initial begin
        int s_count;

        // Reset state and quiet release at the initial level.
        rst = 1'b1;
        d_v[0] = 1'b0; d_v[1] = 1'b0; d_v[2] = 1'b1;
        step();
        step();
        chk("rst_q_a", bus_a.q, 1'b0);
        chk("rst_q_c", bus_c.q, 1'b1);
        chk("rst_pending_a", bus_a.pending, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // A: clean rise with latency to E5; B: toggling every cycle.
        d_v[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d_v[1] = ~d_v[1];
            step();
            chk("rise_q", bus_a.q, logic'(k >= 5));
            chk("rise_s", bus_a.s, logic'(k == 5));
            chk("rise_r", bus_a.r, 1'b0);
            chk("rise_pending", bus_a.pending, logic'(k >= 2 && k <= 4));
            chk("db1_q", bus_b.q, d_v[1]);
            chk("db1_pulse", bus_b.s ^ bus_b.r, 1'b1);
            chk("db1_s_dir", bus_b.s, d_v[1]);
        end

        // Return A to 0, then a 3-cycle high excursion must be rejected.
        d_v[0] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        for (int k = 0; k < 12; k++) begin
            d_v[0] = logic'(k < 3);
            step();
            chk("glitch_q", bus_a.q, 1'b0);
            chk("glitch_s", bus_a.s, 1'b0);
            chk("glitch_r", bus_a.r, 1'b0);
        end
        chk("glitch_pending_end", bus_a.pending, 1'b0);

        // High 3, low 1, high 10: the low cycle restarts the count.
        s_count = 0;
        for (int k = 0; k < 14; k++) begin
            d_v[0] = logic'(k != 3);
            step();
            if (bus_a.s) s_count++;
            chk("restart_s", bus_a.s, logic'(k == 9));
        end
        chk("restart_one_pulse", logic'(s_count == 1), 1'b1);
        chk("restart_q", bus_a.q, 1'b1);

        // Reset mid-count on A (cnt=2) and release of C with d opposite to its init.
        d_v[0] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        d_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("midcount_pending", bus_a.pending, 1'b1);
        rst = 1'b1;
        d_v[2] = 1'b0;
        step();
        chk("rst_abort_s", bus_a.s, 1'b0);
        chk("rst_abort_q", bus_a.q, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("postrst_s", bus_a.s, logic'(k == 5));
            chk("postrst_q", bus_a.q, logic'(k >= 5));
            chk("init1_r", bus_c.r, logic'(k == 3));
            chk("init1_s", bus_c.s, 1'b0);
            chk("init1_q", bus_c.q, logic'(k < 3));
        end

        // Randomized levels with random hold times and occasional resets.
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    d_v[i] = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 7));
                end
                hold[i]--;
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
